// File: rtl/xor_checksum_pkg.sv
// Shared types and sizing helpers for the framed XOR checksum block.
// State encoding for the frame FSM and the beat-counter width function.
// No timing or flow control lives here.
package xor_checksum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must be able to hold MAX_LEN itself, hence the +1.
    function automatic int cnt_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/xor_mux2.sv
// Single-bit 2:1 multiplexer, the only gate the checksum datapath is built from.
// Latency: combinational.
// Backpressure: none.
module xor_mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/xor_vec_using_mux.sv
// WIDTH-bit XOR built purely from 2:1 muxes: y[i] = a[i] ? ~b[i] : b[i].
// Latency: combinational.
// Backpressure: none.
module xor_vec_using_mux #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic b_n;

        // Inverter made from a mux selecting between constants.
        xor_mux2 u_not (
            .sel (b[i]),
            .d0  (1'b1),
            .d1  (1'b0),
            .y   (b_n)
        );

        xor_mux2 u_xor (
            .sel (a[i]),
            .d0  (b[i]),
            .d1  (b_n),
            .y   (y[i])
        );
    end

endmodule

// File: rtl/xor_frame_checksum_mux.sv
// Folds each in_last-terminated frame into one XOR/XNOR checksum with beat count and overflow flag.
// Latency: result valid the cycle after the last beat is accepted.
// Backpressure: in_ready drops while a result waits; the result is held until out_ready.
module xor_frame_checksum_mux
    import xor_checksum_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = cnt_width(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_fold;
    logic [WIDTH-1:0] acc_inv;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic             err;
    logic             in_acc;
    logic             out_hs;

    assign in_acc = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    xor_vec_using_mux #(.WIDTH(WIDTH)) u_fold (
        .a (acc),
        .b (in_data),
        .y (acc_fold)
    );

    // XOR against all-ones yields the bitwise inverse used for XNOR mode.
    xor_vec_using_mux #(.WIDTH(WIDTH)) u_inv (
        .a (acc),
        .b ({WIDTH{1'b1}}),
        .y (acc_inv)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_out_sel
        xor_mux2 u_sel (
            .sel (mode_q),
            .d0  (acc[i]),
            .d1  (acc_inv[i]),
            .y   (out_data[i])
        );
    end

    assign out_count = cnt;
    assign out_err   = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
            err    <= 1'b0;
        end else if (in_acc && state == IDLE) begin
            acc    <= in_data;
            cnt    <= CNT_W'(1);
            mode_q <= mode;
            err    <= 1'b0;
        end else if (in_acc) begin
            // Past MAX_LEN the count saturates but data keeps folding.
            acc <= acc_fold;
            if (cnt == CNT_MAX) begin
                err <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (out_hs) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_frame_checksum_mux.sv
// Self-checking bench for xor_frame_checksum_mux: directed scenarios plus randomized frames.
// Expected checksums come from a plain-arithmetic frame model.
module tb_xor_frame_checksum_mux;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] fd [0:15];
    int               flen;
    logic             fmode;

    xor_frame_checksum_mux #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Presents one beat and returns 1 time unit after the edge that accepted it.
    task automatic drive_beat(input logic [WIDTH-1:0] d, input logic last, input logic m);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode     = m;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        in_last  = 1'($urandom);
        mode     = 1'($urandom);
    endtask

    // Only the first beat's mode should matter; later beats get random mode.
    task automatic send_frame(input bit gaps);
        for (int i = 0; i < flen; i++) begin
            drive_beat(fd[i], (i == flen - 1), (i == 0) ? fmode : 1'($urandom));
            if (gaps && i < flen - 1 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; mode = 1'b0; out_ready = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_count !== '0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_xor();
        flen = 3; fmode = 1'b0; fd[0] = 8'h5A; fd[1] = 8'h3C; fd[2] = 8'hFF;
        send_frame(1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL xor_valid got=%0b exp=1", out_valid); end
        checks++; if (out_data !== 8'h99) begin failures++; $display("FAIL xor_data got=%h exp=99", out_data); end
        checks++; if (out_count !== CNT_W'(3)) begin failures++; $display("FAIL xor_count got=%0d exp=3", out_count); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL xor_err got=%0b exp=0", out_err); end
        handshake();
    endtask

    task automatic test_xnor();
        flen = 3; fmode = 1'b1; fd[0] = 8'h5A; fd[1] = 8'h3C; fd[2] = 8'hFF;
        drive_beat(fd[0], 1'b0, 1'b1);
        drive_beat(fd[1], 1'b0, 1'b0);
        drive_beat(fd[2], 1'b1, 1'b0);
        checks++; if (out_data !== 8'h66) begin failures++; $display("FAIL xnor_data got=%h exp=66", out_data); end
        checks++; if (out_count !== CNT_W'(3)) begin failures++; $display("FAIL xnor_count got=%0d exp=3", out_count); end
        handshake();
    endtask

    task automatic test_single_beat();
        drive_beat(8'hA5, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", out_data); end
        checks++; if (out_count !== CNT_W'(1)) begin failures++; $display("FAIL single_count got=%0d exp=1", out_count); end
        handshake();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_after got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_after got=%0b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        flen = 6; fmode = 1'b0;
        for (int i = 0; i < 6; i++) fd[i] = 8'h01;
        send_frame(1'b0);
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL ovf_data got=%h exp=00", out_data); end
        checks++; if (out_count !== CNT_W'(MAX_LEN)) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", out_count, MAX_LEN); end
        checks++; if (out_err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%0b exp=1", out_err); end
        handshake();
        drive_beat(8'h0F, 1'b1, 1'b0);
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL ovf_next_err got=%0b exp=0", out_err); end
        checks++; if (out_count !== CNT_W'(1)) begin failures++; $display("FAIL ovf_next_count got=%0d exp=1", out_count); end
        checks++; if (out_data !== 8'h0F) begin failures++; $display("FAIL ovf_next_data got=%h exp=0f", out_data); end
        handshake();
    endtask

    task automatic test_backpressure();
        drive_beat(8'h11, 1'b0, 1'b0);
        drive_beat(8'h22, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1; mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", k, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_count !== CNT_W'(2) || out_err !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%0b d=%h c=%0d e=%0b exp v=1 d=33 c=2 e=0", k, out_valid, out_data, out_count, out_err);
            end
            @(posedge clk); #1;
        end
        handshake();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_after_hs got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h77 || out_count !== CNT_W'(1)) begin
            failures++; $display("FAIL bp_next_frame got v=%0b d=%h c=%0d exp v=1 d=77 c=1", out_valid, out_data, out_count);
        end
        handshake();
    endtask

    task automatic test_reset_midframe();
        drive_beat(8'hC3, 1'b0, 1'b1);
        drive_beat(8'h81, 1'b0, 1'b0);
        checks++; if (out_count !== CNT_W'(2)) begin failures++; $display("FAIL rstm_pre_count got=%0d exp=2", out_count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_count !== '0 || out_data !== 8'h00 || out_err !== 1'b0) begin
            failures++; $display("FAIL rstm_clear got d=%h c=%0d e=%0b exp d=00 c=0 e=0", out_data, out_count, out_err);
        end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL rstm_flags got r=%0b v=%0b exp r=1 v=0", in_ready, out_valid);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        drive_beat(8'h12, 1'b0, 1'b0);
        drive_beat(8'h34, 1'b1, 1'b0);
        checks++; if (out_data !== 8'h26 || out_count !== CNT_W'(2)) begin
            failures++; $display("FAIL rstm_next got d=%h c=%0d exp d=26 c=2", out_data, out_count);
        end
        handshake();
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            logic [WIDTH-1:0] exp_d;
            int               exp_c;
            logic             exp_e;
            int               hold;
            flen  = $urandom_range(1, 7);
            fmode = 1'($urandom);
            exp_d = '0;
            for (int i = 0; i < flen; i++) begin
                fd[i] = WIDTH'($urandom);
                exp_d = exp_d ^ fd[i];
            end
            if (fmode) exp_d = ~exp_d;
            exp_c = (flen > MAX_LEN) ? MAX_LEN : flen;
            exp_e = (flen > MAX_LEN);
            hold  = $urandom_range(0, 3);
            send_frame(1'b1);
            for (int k = 0; k <= hold; k++) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_d || out_count !== CNT_W'(exp_c) || out_err !== exp_e) begin
                    failures++;
                    $display("FAIL rand_frame f=%0d len=%0d got v=%0b d=%h c=%0d e=%0b exp v=1 d=%h c=%0d e=%0b",
                             f, flen, out_valid, out_data, out_count, out_err, exp_d, exp_c, exp_e);
                end
                if (k < hold) begin
                    @(posedge clk); #1;
                end
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_xnor();
        test_single_beat();
        test_overflow();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_frame_checksum_mux.md
Name: xor_frame_checksum_mux

Overview:
- Streaming, parametrised successor to the single-bit mux-built XOR gate.
- Accepts WIDTH-bit words over a valid/ready input and folds each frame (terminated by in_last) into a running bitwise XOR, or XNOR when selected.
- Presents one checksum word per frame on a valid/ready output, together with the beat count and an overflow flag.
- Every XOR bit is built from 2:1 mux instances only. Sits between a framed data source and a checksum comparator or sink.

Parameters:
- WIDTH, 8, data and checksum width in bits (≥1).
- MAX_LEN, 16, maximum beats per frame before overflow is flagged (≥1).
- CNT_W, $clog2(MAX_LEN+1), derived width of the beat counter; not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input word.
- in_data  input  WIDTH  input word.
- in_last  input  1  marks the final beat of a frame.
- mode  input  1  0 = XOR checksum, 1 = XNOR (inverted result); sampled on the first beat of each frame.
- out_valid  output  1  checksum available.
- out_ready  input  1  downstream accepts the checksum.
- out_data  output  WIDTH  frame checksum.
- out_count  output  CNT_W  beats accepted in the frame, saturating at MAX_LEN.
- out_err  output  1  frame exceeded MAX_LEN beats.

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous, active-low.
  - Asserting rst_n low immediately forces state IDLE, acc=0, cnt=0, mode_q=0, err=0.
  - Outputs under reset: out_valid=0, out_data=0, out_count=0, out_err=0, in_ready=1.
  - Reset mid-frame or mid-handshake discards the partial frame or pending result; no output is produced for it.
- Accept rule: input beat accepted when in_valid && in_ready at a rising edge. Output handshake completes when out_valid && out_ready.
- States:
  - IDLE: in_ready=1, out_valid=0. On accept: acc<=in_data, cnt<=1, mode_q<=mode, err<=(MAX_LEN==0 ? 0 : 0). Next state is DONE if in_last, else ACCUM.
  - ACCUM: in_ready=1, out_valid=0. On accept: acc<=acc XOR in_data, cnt<=cnt+1 (saturating), in_last→DONE.
  - DONE: in_ready=0, out_valid=1. Outputs:
    - out_data = mode_q ? ~acc : acc, with the inversion also built from mux instances using constants.
    - out_count=cnt, out_err=err.
    - On handshake → IDLE, with acc, cnt and err cleared.
- Overflow: a beat accepted in ACCUM while cnt==MAX_LEN sets err (sticky for the frame).
  - cnt stays at MAX_LEN; acc keeps folding.
  - Frame still closes only on in_last.
- Latency:
  - Last beat accepted at edge k → out_valid high after edge k. Single-beat frame: same one-cycle latency.
  - At least one cycle between frames, because in_ready=0 in DONE.
- Output holding: out_data, out_count and out_err must be held stable while out_valid=1 and out_ready=0.
- in_data, in_last and mode are ignored whenever no accept occurs. mode changes mid-frame have no effect.
- Idle gaps: in_valid=0 inside a frame holds all state unchanged.

Decomposition:
- Package xor_checksum_pkg contains:
  - state enum (IDLE, ACCUM, DONE), 2-bit encoding;
  - a localparam function computing CNT_W.
- One sub-module, xor_vec_using_mux:
  - parametrised WIDTH, generate-loop of 2:1 mux instances;
  - bit i output = a[i] ? ~b[i] : b[i], where ~b[i] is itself produced by a mux with constants 1/0.
  - Used for the accumulator fold; a second instance with b tied to all-ones performs the XNOR inversion.

Test Plan:
- WIDTH=8, mode=0, frame 0x5A,0x3C,0xFF (last on 0xFF), out_ready=1 → one cycle after the last beat: out_valid=1, out_data=0x99, out_count=3, out_err=0.
- Same frame with mode=1 on the first beat (mode toggled to 0 mid-frame) → out_data=0x66, out_count=3.
- Single-beat frame 0xA5 with in_last=1 → out_data=0xA5, out_count=1; handshake returns to IDLE and in_ready=1 on the next cycle.
- MAX_LEN=4, 6-beat frame of 0x01 each (last on 6th) → out_data=0x00, out_count=4, out_err=1. The next frame, 0x0F last, gives out_err=0, out_count=1.
- Backpressure: result pending, out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_data/count/err stable. The input word is accepted only after out_ready=1 completes the handshake.
- Reset: rst_n pulsed low between clock edges after 2 beats of a frame → outputs clear asynchronously. The next frame, 0x12,0x34(last), yields 0x26 with count 2.
